soc_based_fenwick_tree: RTL and testbench

- Memory-mapped Fenwick-tree (binary indexed tree) accelerator for an SoC bus.
- Builds an arr_size-element array by streaming values, supports point-assign updates and range-sum queries, and stores query results in four addressable result registers read back through out.

---
 rtl/soc_based_fenwick_tree.sv | 125 ++++++++++++
 tb/tb_soc_based_fenwick_tree.sv | 113 +++++++++++
 2 files changed

// File: rtl/soc_based_fenwick_tree.sv
// Memory-mapped Fenwick-tree accelerator: streamed build, point-assign update, range-sum query.
// Optional macro FENWICK_RANGE_CHECK_EN: out-of-range queries return all-ones instead of clamping.
module soc_based_fenwick_tree #(
    parameter int data_size = 32,
    parameter int arr_size  = 100
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wen,
    input  logic [1:0]                     cmd,
    input  logic [1:0]                     addr,
    input  logic [$clog2(arr_size)+1:0]    uindex,
    input  logic [$clog2(arr_size)+1:0]    ql,
    input  logic [$clog2(arr_size)+1:0]    qr,
    input  logic [data_size-1:0]           uvalue,
    input  logic [data_size-1:0]           ivalue,
    output logic [data_size-1:0]           out
);
    localparam int IW = $clog2(arr_size) + 2;
    localparam int AW = $clog2(arr_size + 1);

    typedef logic [IW-1:0]        idx_t;
    typedef logic [data_size-1:0] dat_t;
    typedef enum logic [1:0] {
        CMD_BUILD  = 2'b00,
        CMD_QUERY  = 2'b01,
        CMD_UPDATE = 2'b10,
        CMD_NOP    = 2'b11
    } cmd_e;

    dat_t r_a   [1:arr_size];
    dat_t r_t   [1:arr_size];
    dat_t r_res [0:3];
    idx_t r_cnt;

    cmd_e              w_cmd;
    idx_t              w_k, w_l, w_r;
    dat_t              w_bval, w_qres, w_delta;
    logic              w_bok, w_uok;
    logic [AW-1:0]     w_uidx;
    logic [arr_size:1] w_umask;

    function automatic idx_t lowbit(input idx_t x);
        return x & (~x + idx_t'(1));
    endfunction

    // Walk the Fenwick chain downward; at most one step per set bit.
    function automatic dat_t prefix(input idx_t x);
        dat_t s = '0;
        idx_t i = x;
        for (int unsigned j = 0; j < IW; j++) begin
            if (i != '0 && i <= idx_t'(arr_size)) s += r_t[AW'(i)];
            i = i - lowbit(i);
        end
        return s;
    endfunction

    assign w_cmd = cmd_e'(cmd);

    always_comb begin
        w_k    = r_cnt + idx_t'(1);
        w_bok  = (r_cnt < idx_t'(arr_size));
        w_bval = ivalue + (prefix(w_k - idx_t'(1)) - prefix(w_k - lowbit(w_k)));

        w_l = (ql == '0) ? idx_t'(1) : ql;
        w_r = (qr > r_cnt) ? r_cnt : qr;
`ifdef FENWICK_RANGE_CHECK_EN
        if (ql == '0 || ql > qr || qr > r_cnt) w_qres = '1;
        else                                   w_qres = prefix(qr) - prefix(ql - idx_t'(1));
`else
        if (w_l > w_r) w_qres = '0;
        else           w_qres = prefix(w_r) - prefix(w_l - idx_t'(1));
`endif
    end

    // Upward chain from uindex; an overflowing index wraps to 0 and stops marking.
    always_comb begin
        idx_t i;
        w_uok   = (uindex != '0) && (uindex <= r_cnt);
        w_uidx  = w_uok ? AW'(uindex) : AW'(1);
        w_delta = uvalue - r_a[w_uidx];
        w_umask = '0;
        i       = uindex;
        for (int unsigned j = 0; j < IW; j++) begin
            if (w_uok && i != '0 && i <= r_cnt) w_umask[AW'(i)] = 1'b1;
            i = i + lowbit(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 1; i <= arr_size; i++) begin
                r_a[AW'(i)] <= '0;
                r_t[AW'(i)] <= '0;
            end
            for (int unsigned i = 0; i < 4; i++) r_res[i] <= '0;
            r_cnt <= '0;
            out   <= '0;
        end else begin
            out <= r_res[addr];
            case (w_cmd)
                CMD_BUILD: begin
                    if (w_bok) begin
                        r_a[AW'(w_k)] <= ivalue;
                        r_t[AW'(w_k)] <= w_bval;
                        r_cnt         <= w_k;
                    end
                end
                CMD_UPDATE: begin
                    if (w_uok) r_a[w_uidx] <= uvalue;
                    for (int unsigned i = 1; i <= arr_size; i++) begin
                        if (w_umask[AW'(i)]) r_t[AW'(i)] <= r_t[AW'(i)] + w_delta;
                    end
                end
                CMD_QUERY: begin
                    if (wen) begin
                        r_res[addr] <= w_qres;
                        out         <= w_qres;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_soc_based_fenwick_tree.sv
// Directed bench for soc_based_fenwick_tree; expected values computed by hand.
module tb_soc_based_fenwick_tree;
    localparam int DW = 32;
    localparam int IW = 9;

    logic          clk = 1'b0;
    logic          rst, wen;
    logic [1:0]    cmd, addr;
    logic [IW-1:0] uindex, ql, qr;
    logic [DW-1:0] uvalue, ivalue, out;

    int total = 0;
    int bad   = 0;

`ifdef FENWICK_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    soc_based_fenwick_tree #(.data_size(32), .arr_size(100)) dut (
        .clk(clk), .rst(rst), .wen(wen), .cmd(cmd), .addr(addr),
        .uindex(uindex), .ql(ql), .qr(qr), .uvalue(uvalue), .ivalue(ivalue),
        .out(out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] exp);
        total++;
        assert (out === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, out, exp);
        end
    endtask

    task automatic build(input logic [DW-1:0] v);
        cmd = 2'b00; wen = 1'b0; addr = 2'd0; ivalue = v; tick;
    endtask

    task automatic query(input int l, input int r, input logic w, input logic [1:0] a);
        cmd = 2'b01; ql = IW'(l); qr = IW'(r); wen = w; addr = a; tick;
    endtask

    task automatic update(input int u, input logic [DW-1:0] v);
        cmd = 2'b10; wen = 1'b0; addr = 2'd0; uindex = IW'(u); uvalue = v; tick;
    endtask

    task automatic nop(input logic [1:0] a);
        cmd = 2'b11; wen = 1'b0; addr = a; tick;
    endtask

    initial begin
        rst = 1'b0; wen = 1'b0; cmd = 2'b11; addr = 2'd0;
        uindex = '0; ql = '0; qr = '0; uvalue = '0; ivalue = '0;
        tick; tick;
        check("reset_out", 32'd0);
        rst = 1'b1;

        for (int v = 1; v <= 101; v++) build(DW'(v));
        check("build_out_r0", 32'd0);
        query(1, 100, 1'b1, 2'd0);  check("q_1_100", 32'd5050);
        nop(2'd0);                  check("r0_5050", 32'd5050);

        query(1, 25, 1'b1, 2'd0);   check("q_1_25", 32'd325);
        update(2, 32'd0);           check("upd_out_r0", 32'd325);
        query(1, 25, 1'b1, 2'd1);   check("q_1_25_upd", 32'd323);
        query(4, 25, 1'b1, 2'd2);   check("q_4_25", 32'd319);
        query(10, 35, 1'b1, 2'd3);  check("q_10_35", 32'd585);
        nop(2'd0); check("sweep_r0", 32'd325);
        nop(2'd1); check("sweep_r1", 32'd323);
        nop(2'd2); check("sweep_r2", 32'd319);
        nop(2'd3); check("sweep_r3", 32'd585);

        update(0, 32'd77);
        update(150, 32'd77);
        query(1, 3, 1'b1, 2'd0);    check("q_1_3_badupd", 32'd4);
        query(30, 20, 1'b1, 2'd1);  check("q_inverted", RC ? 32'hFFFF_FFFF : 32'd0);
        query(5, 9, 1'b0, 2'd3);    check("q_noen_out", 32'd585);
        nop(2'd0);                  check("r0_kept", 32'd4);
        query(0, 200, 1'b1, 2'd2);  check("q_clamp", RC ? 32'hFFFF_FFFF : 32'd5048);

        update(3, 32'd10);
        query(1, 100, 1'b1, 2'd0);  check("q_all_upd3", 32'd5055);
        query(50, 75, 1'b1, 2'd1);  check("q_50_75", 32'd1625);
        query(100, 100, 1'b1, 2'd2); check("q_100", 32'd100);
        query(1, 1, 1'b1, 2'd3);    check("q_1", 32'd1);

        rst = 1'b0; nop(2'd3);      check("reset2_out", 32'd0);
        rst = 1'b1;
        build(32'hFFFF_FFFF);
        build(32'd2);
        query(1, 2, 1'b1, 2'd0);    check("q_wrap", 32'd1);

        rst = 1'b0; nop(2'd0); rst = 1'b1;
        for (int v = 1; v <= 10; v++) build(DW'(v));
        query(1, 10, 1'b1, 2'd0);   check("q_pre_midrst", 32'd55);
        rst = 1'b0; build(32'd99);  check("midrst_out", 32'd0);
        rst = 1'b1;
        build(32'd5);               check("midrst_r0", 32'd0);
        build(32'd6);
        query(1, 2, 1'b1, 2'd0);    check("q_after_midrst", 32'd11);
        query(1, 50, 1'b1, 2'd1);   check("q_partial", RC ? 32'hFFFF_FFFF : 32'd11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
